zeroheti_obi_arb: RTL and testbench



---
 rtl/zeroheti_pkg.sv | 14 +
 rtl/zeroheti_obi_arb_idfifo.sv | 60 ++++++
 rtl/zeroheti_obi_arb.sv | 111 +++++++++++
 tb/tb_zeroheti_obi_arb.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/zeroheti_pkg.sv
// Shared constants for the zeroheti OBI interconnect: requester indices,
// the default outstanding-transaction depth and an ID-width helper.
package zeroheti_pkg;

  localparam int unsigned IdxCpuIf        = 0;
  localparam int unsigned IdxSba          = 1;
  localparam int unsigned DefaultMaxTrans = 2;

  // Width of an index into n entries; at least one bit so n=1 still works.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zeroheti_obi_arb_idfifo.sv
// FIFO of requester IDs for granted-but-unanswered OBI transactions.
// Pushes are ignored when full and pops are ignored when empty.
module zeroheti_obi_arb_idfifo
  import zeroheti_pkg::*;
#(
  parameter int unsigned Depth = DefaultMaxTrans,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = id_width(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Depth-1:0][Width-1:0] mem;
  logic [PtrW-1:0]             wr_ptr, rd_ptr;
  logic [CntW-1:0]             count;
  logic                        do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count == CntW'(Depth));
  assign empty_o = (count == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/zeroheti_obi_arb.sv
// Round-robin OBI arbiter: N requesters share one subordinate port, with
// request locking until grant and zero-latency response routing by ID FIFO.
module zeroheti_obi_arb
  import zeroheti_pkg::*;
#(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned MaxTrans  = DefaultMaxTrans,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumReq-1:0]                     req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]      addr_i,
  input  logic [NumReq-1:0]                     we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]    be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]      wdata_i,
  output logic [NumReq-1:0]                     gnt_o,
  output logic [NumReq-1:0]                     rvalid_o,
  output logic [DataWidth-1:0]                  rdata_o,
  output logic [NumReq-1:0]                     err_o,
  output logic                                  sbr_req_o,
  output logic [AddrWidth-1:0]                  sbr_addr_o,
  output logic                                  sbr_we_o,
  output logic [DataWidth/8-1:0]                sbr_be_o,
  output logic [DataWidth-1:0]                  sbr_wdata_o,
  input  logic                                  sbr_gnt_i,
  input  logic                                  sbr_rvalid_i,
  input  logic [DataWidth-1:0]                  sbr_rdata_i,
  input  logic                                  sbr_err_i,
  output logic                                  proto_err_o
);

  localparam int unsigned IdW = id_width(NumReq);

  // Handshake: a request phase completes in the cycle where req and gnt are
  // both high; once req is raised the requester holds it and its payload
  // stable until granted. Responses (rvalid) have no back-pressure.

  logic [IdW-1:0] rr_ptr, rr_sel, sel, lock_id, head_id;
  logic           lock, full, empty, hs, pop, found;
  int unsigned    idx;

  always_comb begin
    rr_sel = rr_ptr;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NumReq; i++) begin
      idx = (int'(rr_ptr) + i) % NumReq;
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        rr_sel = IdW'(idx);
      end
    end
  end

  assign sel         = lock ? lock_id : rr_sel;
  assign sbr_req_o   = req_i[sel] & ~full;
  assign sbr_addr_o  = addr_i[sel];
  assign sbr_we_o    = we_i[sel];
  assign sbr_be_o    = be_i[sel];
  assign sbr_wdata_o = wdata_i[sel];
  assign hs          = sbr_req_o & sbr_gnt_i;
  assign pop         = sbr_rvalid_i & ~empty;
  assign rdata_o     = sbr_rdata_i;

  always_comb begin
    gnt_o             = '0;
    rvalid_o          = '0;
    err_o             = '0;
    gnt_o[sel]        = hs;
    rvalid_o[head_id] = pop;
    err_o[head_id]    = pop & sbr_err_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr      <= '0;
      lock        <= 1'b0;
      lock_id     <= '0;
      proto_err_o <= 1'b0;
    end else begin
      if (hs) begin
        lock   <= 1'b0;
        rr_ptr <= (sel == IdW'(NumReq - 1)) ? '0 : sel + IdW'(1);
      end else if (sbr_req_o) begin
        // Pending request keeps the port until the subordinate accepts it.
        lock    <= 1'b1;
        lock_id <= sel;
      end
      if (sbr_rvalid_i && empty) begin
        proto_err_o <= 1'b1;
      end
    end
  end

  zeroheti_obi_arb_idfifo #(
    .Depth (MaxTrans),
    .Width (IdW)
  ) u_idfifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (hs),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_zeroheti_obi_arb.sv
// Bench for zeroheti_obi_arb: directed scenarios plus a random phase, all
// compared cycle by cycle against a queue-based transaction model.
module tb_zeroheti_obi_arb;

  localparam int NumReq   = 2;
  localparam int MaxTrans = 2;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int BW       = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [NumReq-1:0]            req_i = '0;
  logic [NumReq-1:0][AW-1:0]    addr_i = '0;
  logic [NumReq-1:0]            we_i = '0;
  logic [NumReq-1:0][BW-1:0]    be_i = '0;
  logic [NumReq-1:0][DW-1:0]    wdata_i = '0;
  logic [NumReq-1:0]            gnt_o, rvalid_o, err_o;
  logic [DW-1:0]                rdata_o;
  logic                         sbr_req_o, sbr_we_o, proto_err_o;
  logic [AW-1:0]                sbr_addr_o;
  logic [BW-1:0]                sbr_be_o;
  logic [DW-1:0]                sbr_wdata_o;
  logic                         sbr_gnt_i = 1'b0, sbr_rvalid_i = 1'b0, sbr_err_i = 1'b0;
  logic [DW-1:0]                sbr_rdata_i = '0;

  zeroheti_obi_arb #(
    .NumReq(NumReq), .MaxTrans(MaxTrans), .AddrWidth(AW), .DataWidth(DW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
    .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .sbr_req_o(sbr_req_o), .sbr_addr_o(sbr_addr_o),
    .sbr_we_o(sbr_we_o), .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o),
    .sbr_gnt_i(sbr_gnt_i), .sbr_rvalid_i(sbr_rvalid_i), .sbr_rdata_i(sbr_rdata_i),
    .sbr_err_i(sbr_err_i), .proto_err_o(proto_err_o)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int failures = 0;
  logic [0:0] exp_q[$];        // IDs of outstanding transactions, oldest first
  int  m_rr = 0;
  bit  m_lock = 0;
  int  m_lock_id = 0;
  bit  m_proto = 0;

  logic [AW-1:0] pay_addr [NumReq];
  logic          pay_we   [NumReq];
  logic [BW-1:0] pay_be   [NumReq];
  logic [DW-1:0] pay_wdata[NumReq];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rr = 0; m_lock = 0; m_lock_id = 0; m_proto = 0;
  endtask

  task automatic new_payload(input int r);
    pay_addr[r]  = $urandom;
    pay_we[r]    = 1'($urandom_range(0, 1));
    pay_be[r]    = BW'($urandom_range(0, 15));
    pay_wdata[r] = $urandom;
  endtask

  // ---------------- driver: one clock cycle, checked against the model ----
  task automatic cycle(input logic [NumReq-1:0] rq, input logic g, input logic rv,
                       input logic e, output logic [NumReq-1:0] gnt_seen,
                       output logic [NumReq-1:0] rv_seen, output logic [NumReq-1:0] err_seen,
                       output logic req_seen);
    int sel;
    bit full, exp_req, hs, pop;
    logic [NumReq-1:0] exp_gnt, exp_rv, exp_err;
    logic [DW-1:0] rd;
    rd = $urandom;
    req_i = rq; sbr_gnt_i = g; sbr_rvalid_i = rv; sbr_err_i = e; sbr_rdata_i = rd;
    for (int r = 0; r < NumReq; r++) begin
      addr_i[r] = pay_addr[r]; we_i[r] = pay_we[r];
      be_i[r] = pay_be[r]; wdata_i[r] = pay_wdata[r];
    end
    #4;
    // Model: round-robin from m_rr unless a stalled request holds the port.
    sel = m_rr;
    if (m_lock) sel = m_lock_id;
    else begin
      for (int i = NumReq - 1; i >= 0; i--)
        if (rq[(m_rr + i) % NumReq]) sel = (m_rr + i) % NumReq;
    end
    full    = (exp_q.size() == MaxTrans);
    exp_req = rq[sel] && !full;
    hs      = exp_req && g;
    pop     = rv && (exp_q.size() > 0);
    exp_gnt = '0; exp_rv = '0; exp_err = '0;
    if (hs) exp_gnt[sel] = 1'b1;
    if (pop) begin
      exp_rv[exp_q[0]]  = 1'b1;
      exp_err[exp_q[0]] = e;
    end
    check("sbr_req", 64'(sbr_req_o), 64'(exp_req));
    check("gnt", 64'(gnt_o), 64'(exp_gnt));
    check("rvalid", 64'(rvalid_o), 64'(exp_rv));
    check("err", 64'(err_o), 64'(exp_err));
    check("proto_err", 64'(proto_err_o), 64'(m_proto));
    check("rdata", 64'(rdata_o), 64'(rd));
    if (exp_req) begin
      check("sbr_addr", 64'(sbr_addr_o), 64'(pay_addr[sel]));
      check("sbr_we", 64'(sbr_we_o), 64'(pay_we[sel]));
      check("sbr_be", 64'(sbr_be_o), 64'(pay_be[sel]));
      check("sbr_wdata", 64'(sbr_wdata_o), 64'(pay_wdata[sel]));
    end
    gnt_seen = gnt_o; rv_seen = rvalid_o; err_seen = err_o; req_seen = sbr_req_o;
    // Model state update at the clock edge.
    if (rv && exp_q.size() == 0) m_proto = 1;
    if (pop) void'(exp_q.pop_front());
    if (hs) begin
      exp_q.push_back(1'(sel));
      m_rr = (sel + 1) % NumReq;
      m_lock = 0;
    end else if (exp_req) begin
      m_lock = 1; m_lock_id = sel;
    end
    @(posedge clk_i); #1;
  endtask

  task automatic apply_reset();
    req_i = '0; sbr_gnt_i = 0; sbr_rvalid_i = 0; sbr_err_i = 0;
    #2 rst_ni = 1'b0;
    #1;
    check("rst_gnt", 64'(gnt_o), 64'h0);
    check("rst_rvalid", 64'(rvalid_o), 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    check("rst_sbr_req", 64'(sbr_req_o), 64'h0);
    check("rst_proto", 64'(proto_err_o), 64'h0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  logic [NumReq-1:0] gs, rs, es;
  logic qs;
  logic [1:0] seq[4];
  bit pending[NumReq];

  initial begin
    for (int r = 0; r < NumReq; r++) new_payload(r);
    @(posedge clk_i); #1;
    apply_reset();

    // Both requesting, subordinate always granting: strict alternation.
    for (int c = 0; c < 4; c++) begin
      cycle(2'b11, 1'b1, (c > 0), 1'b0, gs, rs, es, qs);
      seq[c] = gs;
    end
    check("alt0", 64'(seq[0]), 64'h1);
    check("alt1", 64'(seq[1]), 64'h2);
    check("alt2", 64'(seq[2]), 64'h1);
    check("alt3", 64'(seq[3]), 64'h2);
    cycle(2'b00, 1'b0, 1'b1, 1'b0, gs, rs, es, qs);

    // Stalled request from 0 holds the port; requester 1 goes first next.
    cycle(2'b01, 1'b0, 1'b0, 1'b0, gs, rs, es, qs);
    cycle(2'b11, 1'b0, 1'b0, 1'b0, gs, rs, es, qs);
    check("lock_nogrant", 64'(gs), 64'h0);
    cycle(2'b11, 1'b0, 1'b0, 1'b0, gs, rs, es, qs);
    cycle(2'b11, 1'b1, 1'b0, 1'b0, gs, rs, es, qs);
    check("lock_grant0", 64'(gs), 64'h1);
    cycle(2'b11, 1'b1, 1'b0, 1'b0, gs, rs, es, qs);
    check("after_lock_grant1", 64'(gs), 64'h2);

    // Outstanding IDs 0 then 1: responses routed in order with their error.
    cycle(2'b00, 1'b0, 1'b1, 1'b0, gs, rs, es, qs);
    check("resp0_rvalid", 64'(rs), 64'h1);
    check("resp0_err", 64'(es), 64'h0);
    cycle(2'b00, 1'b0, 1'b1, 1'b1, gs, rs, es, qs);
    check("resp1_rvalid", 64'(rs), 64'h2);
    check("resp1_err", 64'(es), 64'h2);

    // Fill the ID FIFO; full blocks requests even during a pop.
    cycle(2'b01, 1'b1, 1'b0, 1'b0, gs, rs, es, qs);
    cycle(2'b01, 1'b1, 1'b0, 1'b0, gs, rs, es, qs);
    cycle(2'b01, 1'b1, 1'b0, 1'b0, gs, rs, es, qs);
    check("full_no_req", 64'(qs), 64'h0);
    cycle(2'b01, 1'b1, 1'b1, 1'b0, gs, rs, es, qs);
    check("full_pop_no_req", 64'(qs), 64'h0);
    check("full_pop_rvalid", 64'(rs), 64'h1);
    cycle(2'b01, 1'b1, 1'b0, 1'b0, gs, rs, es, qs);
    check("after_pop_grant", 64'(gs), 64'h1);

    // Reset with transactions outstanding; a late response is a protocol error.
    apply_reset();
    cycle(2'b00, 1'b0, 1'b1, 1'b0, gs, rs, es, qs);
    check("late_rvalid", 64'(rs), 64'h0);
    for (int c = 0; c < 3; c++) cycle(2'b00, 1'b0, 1'b0, 1'b0, gs, rs, es, qs);
    check("proto_sticky", 64'(proto_err_o), 64'h1);
    apply_reset();

    // Random traffic obeying the request-hold rule.
    for (int r = 0; r < NumReq; r++) pending[r] = 0;
    for (int c = 0; c < 400; c++) begin
      logic [NumReq-1:0] rq;
      for (int r = 0; r < NumReq; r++) begin
        if (!pending[r] && $urandom_range(0, 1) == 1) begin
          pending[r] = 1;
          new_payload(r);
        end
        rq[r] = pending[r];
      end
      cycle(rq, ($urandom_range(0, 3) != 0), (exp_q.size() > 0 && $urandom_range(0, 2) == 0),
            1'($urandom_range(0, 1)), gs, rs, es, qs);
      for (int r = 0; r < NumReq; r++) if (gs[r]) pending[r] = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
